// File: rtl/mem_stage_if.sv
// Bundle of the MEM-stage signals: EX/MEM register inputs, data-memory
// handshake and WB-side results. The slave modport is the stage itself;
// the master modport is whoever drives the pipeline and answers dmem.
interface mem_stage_if #(
    parameter int GPR_WIDTH      = 16,
    parameter int PC_WIDTH       = 16,
    parameter int GRP_ADDR_WIDTH = 4
);
    // EX/MEM register contents
    logic                      in_valid;
    logic [GPR_WIDTH-1:0]      alu_data;
    logic [1:0]                alu_flags;
    logic [GPR_WIDTH-1:0]      data_rt;
    logic [PC_WIDTH-1:0]       branch_target;
    logic [PC_WIDTH-1:0]       next_pc;
    logic [GRP_ADDR_WIDTH-1:0] reg_dest;
    logic                      mem_read;
    logic                      mem_write_enable;
    logic                      is_branch;
    logic                      sel_jflag_branch;
    logic                      sel_beq_bne;
    logic                      sel_jt_jf;
    logic                      cond_sel;
    logic                      fl_write_enable;
    logic                      reg_write_enable;
    logic [1:0]                wb_res_mux;

    // Data memory handshake
    logic                      dmem_req;
    logic                      dmem_we;
    logic [GPR_WIDTH-1:0]      dmem_addr;
    logic [GPR_WIDTH-1:0]      dmem_wdata;
    logic [GPR_WIDTH-1:0]      dmem_rdata;
    logic                      dmem_ack;

    // Pipeline control and WB-side results
    logic                      stall;
    logic                      branch_taken;
    logic [PC_WIDTH-1:0]       branch_pc;
    logic                      mem_error;
    logic                      out_valid;
    logic [GPR_WIDTH-1:0]      out_mem_data;
    logic [GPR_WIDTH-1:0]      out_alu_data;
    logic [PC_WIDTH-1:0]       out_next_pc;
    logic [GRP_ADDR_WIDTH-1:0] out_reg_dest;
    logic [1:0]                out_wb_res_mux;
    logic                      out_reg_write_enable;
    logic [1:0]                flag_reg;

    modport master (
        output in_valid, alu_data, alu_flags, data_rt, branch_target, next_pc,
               reg_dest, mem_read, mem_write_enable, is_branch, sel_jflag_branch,
               sel_beq_bne, sel_jt_jf, cond_sel, fl_write_enable, reg_write_enable,
               wb_res_mux, dmem_rdata, dmem_ack,
        input  dmem_req, dmem_we, dmem_addr, dmem_wdata, stall, branch_taken,
               branch_pc, mem_error, out_valid, out_mem_data, out_alu_data,
               out_next_pc, out_reg_dest, out_wb_res_mux, out_reg_write_enable,
               flag_reg
    );

    modport slave (
        input  in_valid, alu_data, alu_flags, data_rt, branch_target, next_pc,
               reg_dest, mem_read, mem_write_enable, is_branch, sel_jflag_branch,
               sel_beq_bne, sel_jt_jf, cond_sel, fl_write_enable, reg_write_enable,
               wb_res_mux, dmem_rdata, dmem_ack,
        output dmem_req, dmem_we, dmem_addr, dmem_wdata, stall, branch_taken,
               branch_pc, mem_error, out_valid, out_mem_data, out_alu_data,
               out_next_pc, out_reg_dest, out_wb_res_mux, out_reg_write_enable,
               flag_reg
    );
endinterface

// File: rtl/mem_stage.sv
// MEM pipeline stage: issues data-memory accesses with a bounded wait,
// resolves conditional branches/jumps, keeps the 2-bit flag register and
// registers the results handed to write-back.
module mem_stage #(
    parameter int WAIT_LIMIT     = 8,
    parameter int GPR_WIDTH      = 16,
    parameter int PC_WIDTH       = 16,
    parameter int GRP_ADDR_WIDTH = 4
) (
    input  logic          clk,
    input  logic          rst,     // asynchronous, active-low
    mem_stage_if.slave    bus
);
    localparam int CNT_W = $clog2(WAIT_LIMIT + 1);
    localparam logic [CNT_W-1:0] LIMIT_M1 = CNT_W'(WAIT_LIMIT - 1);

    typedef enum logic {ST_IDLE, ST_WAIT} state_t;

    state_t                    state_q, state_d;
    logic [CNT_W-1:0]          cnt_q, cnt_d;

    logic                      out_valid_q;
    logic [GPR_WIDTH-1:0]      out_mem_data_q;
    logic [GPR_WIDTH-1:0]      out_alu_data_q;
    logic [PC_WIDTH-1:0]       out_next_pc_q;
    logic [GRP_ADDR_WIDTH-1:0] out_reg_dest_q;
    logic [1:0]                out_wb_res_mux_q;
    logic                      out_rwe_q;
    logic                      branch_taken_q;
    logic [PC_WIDTH-1:0]       branch_pc_q;
    logic [1:0]                flag_reg_q;
    logic                      mem_error_q;

    logic is_mem;
    logic accept;
    logic ack_w;
    logic abort_w;
    logic br_cond;
    logic in_wait;

    assign is_mem  = bus.mem_read | bus.mem_write_enable;
    assign accept  = (state_q == ST_IDLE) && bus.in_valid;
    assign in_wait = (state_q == ST_WAIT);

    // Branch condition; jt/jf read the flag register as it was before this edge
    assign br_cond = bus.sel_jflag_branch ? (flag_reg_q[bus.cond_sel] ^ bus.sel_jt_jf)
                                          : (bus.alu_flags[0] ^ bus.sel_beq_bne);

    // Next state, wait counter and completion/abort decode
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        ack_w   = 1'b0;
        abort_w = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (accept && is_mem) begin
                    state_d = ST_WAIT;
                    cnt_d   = '0;
                end
            end
            ST_WAIT: begin
                if (bus.dmem_ack) begin
                    ack_w   = 1'b1;
                    state_d = ST_IDLE;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                    if (cnt_q == LIMIT_M1) begin
                        abort_w = 1'b1;
                        state_d = ST_IDLE;
                    end
                end
            end
        endcase
    end

    // State and wait-counter registers
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // Write-back results: captured at acceptance, memory data at completion
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            out_valid_q      <= 1'b0;
            out_mem_data_q   <= '0;
            out_alu_data_q   <= '0;
            out_next_pc_q    <= '0;
            out_reg_dest_q   <= '0;
            out_wb_res_mux_q <= '0;
            out_rwe_q        <= 1'b0;
        end else begin
            out_valid_q <= (accept && !is_mem) || ack_w || abort_w;
            if (accept) begin
                out_mem_data_q   <= '0;
                out_alu_data_q   <= bus.alu_data;
                out_next_pc_q    <= bus.next_pc;
                out_reg_dest_q   <= bus.reg_dest;
                out_wb_res_mux_q <= bus.wb_res_mux;
                out_rwe_q        <= bus.reg_write_enable;
            end
            if (ack_w) begin
                out_mem_data_q <= bus.mem_read ? bus.dmem_rdata : '0;
            end
            if (abort_w) begin
                out_mem_data_q <= '0;
                out_rwe_q      <= 1'b0;
            end
        end
    end

    // Branch pulse/target, flag register and sticky error flag
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            branch_taken_q <= 1'b0;
            branch_pc_q    <= '0;
            flag_reg_q     <= '0;
            mem_error_q    <= 1'b0;
        end else begin
            branch_taken_q <= accept && bus.is_branch && br_cond;
            if (accept && bus.is_branch && br_cond) begin
                branch_pc_q <= bus.branch_target;
            end
            if (accept && bus.fl_write_enable) begin
                flag_reg_q <= bus.alu_flags;
            end
            if (abort_w) begin
                mem_error_q <= 1'b1;
            end
        end
    end

    // Memory request is driven straight from the held EX/MEM contents while waiting
    assign bus.dmem_req   = in_wait;
    assign bus.dmem_we    = in_wait & bus.mem_write_enable;
    assign bus.dmem_addr  = in_wait ? bus.alu_data : '0;
    assign bus.dmem_wdata = in_wait ? bus.data_rt : '0;

    // Hold EX/MEM while a memory op is pending; release in the ack cycle
    assign bus.stall = rst && (((state_q == ST_IDLE) && bus.in_valid && is_mem) ||
                               (in_wait && !bus.dmem_ack));

    assign bus.branch_taken         = branch_taken_q;
    assign bus.branch_pc            = branch_pc_q;
    assign bus.mem_error            = mem_error_q;
    assign bus.out_valid            = out_valid_q;
    assign bus.out_mem_data         = out_mem_data_q;
    assign bus.out_alu_data         = out_alu_data_q;
    assign bus.out_next_pc          = out_next_pc_q;
    assign bus.out_reg_dest         = out_reg_dest_q;
    assign bus.out_wb_res_mux       = out_wb_res_mux_q;
    assign bus.out_reg_write_enable = out_rwe_q;
    assign bus.flag_reg             = flag_reg_q;
endmodule

// File: tb/tb_mem_stage.sv
// Self-checking bench for mem_stage: expected retirements are queued when an
// instruction is presented and compared when out_valid is seen.
module tb_mem_stage;
    localparam int GW = 16;
    localparam int PW = 16;
    localparam int AW = 4;
    localparam int WL = 8;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    mem_stage_if #(.GPR_WIDTH(GW), .PC_WIDTH(PW), .GRP_ADDR_WIDTH(AW)) bus ();

    mem_stage #(.WAIT_LIMIT(WL), .GPR_WIDTH(GW), .PC_WIDTH(PW), .GRP_ADDR_WIDTH(AW)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    typedef struct packed {
        logic [15:0] mem_data;
        logic [15:0] alu_data;
        logic [15:0] next_pc;
        logic [3:0]  reg_dest;
        logic [1:0]  wb;
        logic        rwe;
        logic        br;
        logic [15:0] br_pc;
        logic [1:0]  flags;
    } exp_t;

    exp_t sb[$];
    int   checks = 0;
    int   errors = 0;
    int   valid_cnt = 0;
    int   rq, st, v0;

    always @(negedge clk) if (bus.out_valid) valid_cnt++;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic clear_inputs();
        bus.in_valid = 0; bus.alu_data = 0; bus.alu_flags = 0; bus.data_rt = 0;
        bus.branch_target = 0; bus.next_pc = 0; bus.reg_dest = 0; bus.mem_read = 0;
        bus.mem_write_enable = 0; bus.is_branch = 0; bus.sel_jflag_branch = 0;
        bus.sel_beq_bne = 0; bus.sel_jt_jf = 0; bus.cond_sel = 0; bus.fl_write_enable = 0;
        bus.reg_write_enable = 0; bus.wb_res_mux = 0; bus.dmem_rdata = 0; bus.dmem_ack = 0;
    endtask

    task automatic set_op(input logic [15:0] alu, input logic [3:0] rd, input logic rwe,
                          input logic mrd, input logic mwr, input logic [15:0] wdata,
                          input logic [15:0] npc, input logic [1:0] wb);
        clear_inputs();
        bus.alu_data = alu; bus.reg_dest = rd; bus.reg_write_enable = rwe;
        bus.mem_read = mrd; bus.mem_write_enable = mwr; bus.data_rt = wdata;
        bus.next_pc = npc; bus.wb_res_mux = wb;
    endtask

    task automatic expect_ret(input logic [15:0] mem, input logic [15:0] alu, input logic [15:0] npc,
                              input logic [3:0] rd, input logic [1:0] wb, input logic rwe,
                              input logic br, input logic [15:0] brpc, input logic [1:0] flags);
        exp_t e;
        e.mem_data = mem; e.alu_data = alu; e.next_pc = npc; e.reg_dest = rd; e.wb = wb;
        e.rwe = rwe; e.br = br; e.br_pc = brpc; e.flags = flags;
        sb.push_back(e);
    endtask

    // Present the op at a negedge, answer dmem after ack_after idle WAIT cycles
    // (negative: never), and compare the retirement against the queue head.
    task automatic run_txn(input string tag, input int ack_after, input logic [15:0] rdata,
                           input logic [15:0] addr, input logic we, input logic [15:0] wdata,
                           output int req_cycles, output int stall_cycles);
        exp_t e;
        bit done;
        done = 0;
        req_cycles = 0;
        bus.in_valid = 1;
        #1;
        stall_cycles = bus.stall ? 1 : 0;
        for (int i = 0; i < 40 && !done; i++) begin
            @(negedge clk);
            if (bus.out_valid) begin
                done = 1;
                bus.in_valid = 0;
                bus.dmem_ack = 0;
                check({tag, "_sbsize"}, sb.size(), 1);
                if (sb.size() > 0) begin
                    e = sb.pop_front();
                    check({tag, "_mem_data"}, bus.out_mem_data, e.mem_data);
                    check({tag, "_alu_data"}, bus.out_alu_data, e.alu_data);
                    check({tag, "_next_pc"}, bus.out_next_pc, e.next_pc);
                    check({tag, "_reg_dest"}, bus.out_reg_dest, e.reg_dest);
                    check({tag, "_wb_mux"}, bus.out_wb_res_mux, e.wb);
                    check({tag, "_rwe"}, bus.out_reg_write_enable, e.rwe);
                    check({tag, "_br_taken"}, bus.branch_taken, e.br);
                    check({tag, "_br_pc"}, bus.branch_pc, e.br_pc);
                    check({tag, "_flags"}, bus.flag_reg, e.flags);
                end
                $display("txn %s: mem=0x%0h alu=0x%0h rd=%0d rwe=%0b br=%0b pc=0x%0h flags=%0b req=%0d",
                         tag, bus.out_mem_data, bus.out_alu_data, bus.out_reg_dest,
                         bus.out_reg_write_enable, bus.branch_taken, bus.branch_pc,
                         bus.flag_reg, req_cycles);
            end else if (bus.dmem_req) begin
                req_cycles++;
                check({tag, "_addr"}, bus.dmem_addr, addr);
                check({tag, "_we"}, bus.dmem_we, we);
                check({tag, "_wdata"}, bus.dmem_wdata, wdata);
                if (ack_after >= 0 && req_cycles == ack_after + 1) begin
                    bus.dmem_ack = 1;
                    bus.dmem_rdata = rdata;
                end
                #1;
                if (bus.stall) stall_cycles++;
            end
        end
        check({tag, "_retired"}, done, 1);
        bus.in_valid = 0;
    endtask

    initial begin
        clear_inputs();
        // Reset state, including stall forced low with a memory op presented
        bus.in_valid = 1; bus.mem_read = 1;
        #2;
        check("rst_stall", bus.stall, 0);
        check("rst_dmem_req", bus.dmem_req, 0);
        check("rst_out_valid", bus.out_valid, 0);
        check("rst_branch_taken", bus.branch_taken, 0);
        check("rst_mem_error", bus.mem_error, 0);
        check("rst_flag_reg", bus.flag_reg, 0);
        check("rst_out_alu", bus.out_alu_data, 0);
        check("rst_out_rwe", bus.out_reg_write_enable, 0);
        clear_inputs();
        @(negedge clk); @(negedge clk);
        rst = 1;
        @(negedge clk);

        // ALU op, one-cycle latency
        set_op(16'h1234, 4'd3, 1'b1, 1'b0, 1'b0, 16'h0, 16'h0010, 2'd2);
        expect_ret(16'h0, 16'h1234, 16'h0010, 4'd3, 2'd2, 1'b1, 1'b0, 16'h0, 2'b00);
        run_txn("alu", -1, 16'h0, 16'h0, 1'b0, 16'h0, rq, st);
        check("alu_stall_cycles", st, 0);
        check("alu_req_cycles", rq, 0);

        // Load acknowledged after three idle WAIT cycles
        set_op(16'h0040, 4'd5, 1'b1, 1'b1, 1'b0, 16'h0, 16'h0014, 2'd1);
        expect_ret(16'hCAFE, 16'h0040, 16'h0014, 4'd5, 2'd1, 1'b1, 1'b0, 16'h0, 2'b00);
        run_txn("load", 3, 16'hCAFE, 16'h0040, 1'b0, 16'h0, rq, st);
        check("load_stall_cycles", st, 4);
        check("load_req_cycles", rq, 4);
        @(negedge clk);
        check("load_pulse_width", bus.out_valid, 0);
        check("load_idle_req", bus.dmem_req, 0);

        // Store acknowledged immediately: memory data stays zero
        set_op(16'h0050, 4'd7, 1'b1, 1'b0, 1'b1, 16'h1357, 16'h0016, 2'd0);
        expect_ret(16'h0, 16'h0050, 16'h0016, 4'd7, 2'd0, 1'b1, 1'b0, 16'h0, 2'b00);
        run_txn("store_ack", 0, 16'hFFFF, 16'h0050, 1'b1, 16'h1357, rq, st);
        check("store_ack_req_cycles", rq, 1);
        check("store_ack_no_error", bus.mem_error, 0);

        // Store never acknowledged: abort at the wait limit
        set_op(16'h0088, 4'd6, 1'b1, 1'b0, 1'b1, 16'h5A5A, 16'h0018, 2'd3);
        expect_ret(16'h0, 16'h0088, 16'h0018, 4'd6, 2'd3, 1'b0, 1'b0, 16'h0, 2'b00);
        run_txn("store_abort", -1, 16'h0, 16'h0088, 1'b1, 16'h5A5A, rq, st);
        check("abort_req_cycles", rq, WL);
        check("abort_mem_error", bus.mem_error, 1);
        @(negedge clk);
        check("abort_idle_req", bus.dmem_req, 0);
        check("abort_idle_stall", bus.stall, 0);
        check("abort_error_sticky", bus.mem_error, 1);

        // Ack while idle is ignored
        bus.dmem_ack = 1; bus.dmem_rdata = 16'hBEEF;
        #1 v0 = valid_cnt;
        repeat (3) @(negedge clk);
        #1;
        check("idle_ack_no_valid", valid_cnt, v0);
        check("idle_ack_no_req", bus.dmem_req, 0);
        bus.dmem_ack = 0;

        // Flag write with jt on old flags: not taken, flags become 01
        set_op(16'h0, 4'd1, 1'b0, 1'b0, 1'b0, 16'h0, 16'h0020, 2'd0);
        bus.fl_write_enable = 1; bus.is_branch = 1; bus.sel_jflag_branch = 1;
        bus.sel_jt_jf = 0; bus.cond_sel = 0; bus.alu_flags = 2'b01; bus.branch_target = 16'h0300;
        expect_ret(16'h0, 16'h0, 16'h0020, 4'd1, 2'd0, 1'b0, 1'b0, 16'h0, 2'b01);
        run_txn("jt_first", -1, 16'h0, 16'h0, 1'b0, 16'h0, rq, st);

        // Following jt sees flag_reg[0]=1; no flag write
        set_op(16'h0, 4'd1, 1'b0, 1'b0, 1'b0, 16'h0, 16'h0024, 2'd0);
        bus.is_branch = 1; bus.sel_jflag_branch = 1; bus.sel_jt_jf = 0; bus.cond_sel = 0;
        bus.alu_flags = 2'b10; bus.branch_target = 16'h0300;
        expect_ret(16'h0, 16'h0, 16'h0024, 4'd1, 2'd0, 1'b0, 1'b1, 16'h0300, 2'b01);
        run_txn("jt_second", -1, 16'h0, 16'h0, 1'b0, 16'h0, rq, st);

        // bne with zero flag clear: taken
        set_op(16'h0, 4'd0, 1'b0, 1'b0, 1'b0, 16'h0, 16'h0028, 2'd0);
        bus.is_branch = 1; bus.sel_beq_bne = 1; bus.alu_flags = 2'b10; bus.branch_target = 16'h0080;
        expect_ret(16'h0, 16'h0, 16'h0028, 4'd0, 2'd0, 1'b0, 1'b1, 16'h0080, 2'b01);
        run_txn("bne", -1, 16'h0, 16'h0, 1'b0, 16'h0, rq, st);

        // beq with zero flag clear: not taken, branch_pc holds
        set_op(16'h0, 4'd0, 1'b0, 1'b0, 1'b0, 16'h0, 16'h002C, 2'd0);
        bus.is_branch = 1; bus.sel_beq_bne = 0; bus.alu_flags = 2'b00; bus.branch_target = 16'h0999;
        expect_ret(16'h0, 16'h0, 16'h002C, 4'd0, 2'd0, 1'b0, 1'b0, 16'h0080, 2'b01);
        run_txn("beq_nt", -1, 16'h0, 16'h0, 1'b0, 16'h0, rq, st);

        // jf on flag[1] uses the pre-update value (0) while flags load 11
        set_op(16'h0, 4'd2, 1'b0, 1'b0, 1'b0, 16'h0, 16'h0030, 2'd0);
        bus.is_branch = 1; bus.sel_jflag_branch = 1; bus.sel_jt_jf = 1; bus.cond_sel = 1;
        bus.fl_write_enable = 1; bus.alu_flags = 2'b11; bus.branch_target = 16'h0090;
        expect_ret(16'h0, 16'h0, 16'h0030, 4'd2, 2'd0, 1'b0, 1'b1, 16'h0090, 2'b11);
        run_txn("jf_old_flag", -1, 16'h0, 16'h0, 1'b0, 16'h0, rq, st);

        // jf on flag[1] now 1: not taken
        set_op(16'h0, 4'd2, 1'b0, 1'b0, 1'b0, 16'h0, 16'h0034, 2'd0);
        bus.is_branch = 1; bus.sel_jflag_branch = 1; bus.sel_jt_jf = 1; bus.cond_sel = 1;
        bus.branch_target = 16'h00A0;
        expect_ret(16'h0, 16'h0, 16'h0034, 4'd2, 2'd0, 1'b0, 1'b0, 16'h0090, 2'b11);
        run_txn("jf_nt", -1, 16'h0, 16'h0, 1'b0, 16'h0, rq, st);

        // Branch combined with a load: branch resolves, access still runs
        set_op(16'h0060, 4'd9, 1'b1, 1'b1, 1'b0, 16'h0, 16'h0038, 2'd1);
        bus.is_branch = 1; bus.sel_beq_bne = 0; bus.alu_flags = 2'b01; bus.branch_target = 16'h00B0;
        expect_ret(16'h7777, 16'h0060, 16'h0038, 4'd9, 2'd1, 1'b1, 1'b0, 16'h00B0, 2'b11);
        run_txn("br_load", 1, 16'h7777, 16'h0060, 1'b0, 16'h0, rq, st);
        check("br_load_req_cycles", rq, 2);

        // Reset asserted mid-WAIT
        set_op(16'h0044, 4'd4, 1'b1, 1'b1, 1'b0, 16'h0, 16'h003C, 2'd1);
        bus.in_valid = 1;
        @(negedge clk); @(negedge clk);
        check("midwait_req_before", bus.dmem_req, 1);
        #1 v0 = valid_cnt;
        rst = 0;
        #1;
        check("midwait_req_dropped", bus.dmem_req, 0);
        check("midwait_stall_dropped", bus.stall, 0);
        check("midwait_error_cleared", bus.mem_error, 0);
        bus.in_valid = 0;
        @(negedge clk);
        rst = 1;
        repeat (3) @(negedge clk);
        #1;
        check("midwait_no_valid", valid_cnt, v0);
        check("midwait_idle_req", bus.dmem_req, 0);
        check("midwait_flags_cleared", bus.flag_reg, 0);

        // Stage accepts normally after the reset
        set_op(16'h4321, 4'd8, 1'b1, 1'b0, 1'b0, 16'h0, 16'h0040, 2'd2);
        expect_ret(16'h0, 16'h4321, 16'h0040, 4'd8, 2'd2, 1'b1, 1'b0, 16'h0, 2'b00);
        run_txn("post_rst_alu", -1, 16'h0, 16'h0, 1'b0, 16'h0, rq, st);

        check("sb_empty", sb.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
